// File: rtl/data_cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_cache_pkg
//  Description : Shared types and width helpers for the write-back data cache.
//                Holds the controller state encoding and the clog2-based
//                helpers that split a byte address into tag/index/word fields.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COMPARE   = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_REFILL    = 3'd3,
        ST_RESPOND   = 3'd4
    } state_e;

    // Field width for n items; a single item needs no select bits.
    function automatic int log2_ceil(input int n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction

    function automatic int byte_off_w(input int data_w);
        return log2_ceil(data_w / 8);
    endfunction

    function automatic int tag_w(input int addr_w, input int data_w,
                                 input int num_lines, input int words);
        return addr_w - byte_off_w(data_w) - log2_ceil(words) - log2_ceil(num_lines);
    endfunction

    // Vector width that is never zero, for counters over a possibly empty field.
    function automatic int nz_w(input int w);
        return (w > 0) ? w : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_cache_tag_ram.sv
`default_nettype none
// ============================================================================
//  Module      : data_cache_tag_ram
//  Description : Per-line valid/dirty/tag storage. Asynchronous read,
//                synchronous single-port write. Valid and dirty bits clear
//                asynchronously on reset_n; tags are left uninitialised.
//  Ports       : rd_idx_i -> rd_valid_o/rd_dirty_o/rd_tag_o (combinational)
//                wr_en_i/wr_idx_i/wr_tag_i/wr_valid_i/wr_dirty_i (whole entry)
//  Revision    : 1.0 - initial release
// ============================================================================
module data_cache_tag_ram #(
    parameter int NUM_LINES = 64,
    parameter int IX_W      = 6,
    parameter int TAG_W     = 22
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IX_W-1:0]  rd_idx_i,
    output logic             rd_valid_o,
    output logic             rd_dirty_o,
    output logic [TAG_W-1:0] rd_tag_o,
    input  logic             wr_en_i,
    input  logic [IX_W-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic             wr_valid_i,
    input  logic             wr_dirty_i
);
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q [NUM_LINES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= wr_valid_i;
            dirty_q[wr_idx_i] <= wr_dirty_i;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];

endmodule
`default_nettype wire

// File: rtl/data_cache_wb.sv
`default_nettype none
// ============================================================================
//  Module      : data_cache_wb
//  Description : Direct-mapped, write-back, write-allocate data cache with
//                multi-word lines, burst refill/writeback and saturating
//                hit/miss counters.
//  Ports       : cpu_req_*  - valid/ready request from the load/store unit
//                cpu_resp_* - one-cycle response pulse (rdata, hit flag)
//                mem_*      - word-wide beat port, per-beat valid/ready
//                perf_*     - saturating hit/miss counters
//  Revision    : 1.0 - initial release
// ============================================================================
module data_cache_wb
    import data_cache_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int NUM_LINES      = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_write,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_rdata,
    output logic              cpu_resp_hit,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_misses
);
    localparam int BO    = byte_off_w(DATA_W);
    localparam int WO    = log2_ceil(WORDS_PER_LINE);
    localparam int IX    = log2_ceil(NUM_LINES);
    localparam int TW    = tag_w(ADDR_W, DATA_W, NUM_LINES, WORDS_PER_LINE);
    localparam int BW    = nz_w(WO);
    localparam int DA    = IX + WO;
    localparam int DEPTH = NUM_LINES * WORDS_PER_LINE;
    localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS_PER_LINE - 1);

    state_e            state_q, state_d;
    logic              req_write_q, req_write_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              hit_q, hit_d;
    logic [31:0]       hits_q, hits_d, misses_q, misses_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_hit_q, resp_hit_d;

    logic [DATA_W-1:0] data_q [DEPTH];

    // Address decode of the registered request. Shifting first keeps the
    // word field well defined even when a line holds a single word.
    logic [ADDR_W-1:0] addr_sh_bo, addr_sh_ix, addr_sh_tag;
    logic [BW-1:0]     req_word;
    logic [IX-1:0]     req_idx;
    logic [TW-1:0]     req_tag;
    logic [DA-1:0]     req_daddr, beat_daddr;
    logic              unused_addr_bits;

    assign addr_sh_bo  = req_addr_q >> BO;
    assign addr_sh_ix  = req_addr_q >> (BO + WO);
    assign addr_sh_tag = req_addr_q >> (BO + WO + IX);
    assign req_word    = addr_sh_bo[BW-1:0] & LAST_BEAT;
    assign req_idx     = addr_sh_ix[IX-1:0];
    assign req_tag     = addr_sh_tag[TW-1:0];
    assign req_daddr   = (DA'(req_idx) << WO) | DA'(req_word);
    assign beat_daddr  = (DA'(req_idx) << WO) | DA'(beat_q);
    assign unused_addr_bits = ^{addr_sh_bo[ADDR_W-1:BW], addr_sh_ix[ADDR_W-1:IX],
                                addr_sh_tag[ADDR_W-1:TW]};

    // Tag RAM: looked up with the request index for the whole transaction
    logic          tr_valid, tr_dirty, tw_en, tw_dirty;
    logic [TW-1:0] tr_tag;

    data_cache_tag_ram #(
        .NUM_LINES (NUM_LINES),
        .IX_W      (IX),
        .TAG_W     (TW)
    ) u_tag_ram (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_idx_i   (req_idx),
        .rd_valid_o (tr_valid),
        .rd_dirty_o (tr_dirty),
        .rd_tag_o   (tr_tag),
        .wr_en_i    (tw_en),
        .wr_idx_i   (req_idx),
        .wr_tag_i   (req_tag),
        .wr_valid_i (1'b1),
        .wr_dirty_i (tw_dirty)
    );

    logic              lookup_hit;
    logic [ADDR_W-1:0] beat_low, wb_addr, rf_addr;
    logic              dwr_en;
    logic [DA-1:0]     dwr_addr;
    logic [DATA_W-1:0] dwr_data;

    assign lookup_hit = tr_valid && (tr_tag == req_tag);
    assign beat_low   = (ADDR_W'(req_idx) << (BO + WO)) | (ADDR_W'(beat_q) << BO);
    assign wb_addr    = (ADDR_W'(tr_tag) << (BO + WO + IX)) | beat_low;
    assign rf_addr    = (ADDR_W'(req_tag) << (BO + WO + IX)) | beat_low;

    // Memory-side outputs decode straight from the state register so an
    // asynchronous reset drops mem_valid without waiting for a clock edge.
    always_comb begin
        state_d      = state_q;
        req_write_d  = req_write_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        beat_d       = beat_q;
        hit_d        = hit_q;
        hits_d       = hits_q;
        misses_d     = misses_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_hit_d   = resp_hit_q;
        cpu_req_ready = 1'b0;
        mem_valid    = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        tw_en        = 1'b0;
        tw_dirty     = 1'b0;
        dwr_en       = 1'b0;
        dwr_addr     = req_daddr;
        dwr_data     = req_wdata_q;

        case (state_q)
            ST_IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) begin
                    req_write_d = cpu_req_write;
                    req_addr_d  = cpu_req_addr;
                    req_wdata_d = cpu_req_wdata;
                    state_d     = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                beat_d = '0;
                hit_d  = lookup_hit;
                if (lookup_hit) begin
                    if (hits_q != 32'hFFFF_FFFF) hits_d = hits_q + 32'd1;
                    state_d = ST_RESPOND;
                end else begin
                    if (misses_q != 32'hFFFF_FFFF) misses_d = misses_q + 32'd1;
                    state_d = (tr_valid && tr_dirty) ? ST_WRITEBACK : ST_REFILL;
                end
            end
            ST_WRITEBACK: begin
                mem_valid = 1'b1;
                mem_write = 1'b1;
                mem_addr  = wb_addr;
                mem_wdata = data_q[beat_daddr];
                if (mem_ready) begin
                    beat_d = beat_q + BW'(1);
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = ST_REFILL;
                    end
                end
            end
            ST_REFILL: begin
                mem_valid = 1'b1;
                mem_addr  = rf_addr;
                if (mem_ready) begin
                    dwr_en   = 1'b1;
                    dwr_addr = beat_daddr;
                    dwr_data = mem_rdata;
                    beat_d   = beat_q + BW'(1);
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        tw_en   = 1'b1;
                        state_d = ST_RESPOND;
                    end
                end
            end
            ST_RESPOND: begin
                // Hits and filled misses both finish here, so the access
                // itself lives in one place and hit latency is fixed.
                resp_valid_d = 1'b1;
                resp_hit_d   = hit_q;
                if (req_write_q) begin
                    dwr_en       = 1'b1;
                    tw_en        = 1'b1;
                    tw_dirty     = 1'b1;
                    resp_rdata_d = req_wdata_q;
                end else begin
                    resp_rdata_d = data_q[req_daddr];
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            req_write_q  <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            beat_q       <= '0;
            hit_q        <= 1'b0;
            hits_q       <= '0;
            misses_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_hit_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_write_q  <= req_write_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            beat_q       <= beat_d;
            hit_q        <= hit_d;
            hits_q       <= hits_d;
            misses_q     <= misses_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_hit_q   <= resp_hit_d;
        end
    end

    always_ff @(posedge clk) begin
        if (dwr_en) begin
            data_q[dwr_addr] <= dwr_data;
        end
    end

    assign cpu_resp_valid = resp_valid_q;
    assign cpu_resp_rdata = resp_rdata_q;
    assign cpu_resp_hit   = resp_hit_q;
    assign perf_hits      = hits_q;
    assign perf_misses    = misses_q;

endmodule
`default_nettype wire

// File: tb/tb_data_cache_wb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_cache_wb
//  Description : Self-checking bench for data_cache_wb (64 lines x 4 words).
//                A memory model answers beats (word = addr ^ 32'hA5A5_0000
//                unless written back) and checks them against a queue of
//                expected beats; responses are checked against a queue of
//                expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_cache_wb;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_ready;
    logic        cpu_req_write = 1'b0;
    logic [31:0] cpu_req_addr = '0;
    logic [31:0] cpu_req_wdata = '0;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_rdata;
    logic        cpu_resp_hit;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [31:0] perf_hits;
    logic [31:0] perf_misses;

    data_cache_wb #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .NUM_LINES      (64),
        .WORDS_PER_LINE (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_req_write  (cpu_req_write),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_wdata  (cpu_req_wdata),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_rdata (cpu_resp_rdata),
        .cpu_resp_hit   (cpu_resp_hit),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .perf_hits      (perf_hits),
        .perf_misses    (perf_misses)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic write; logic [31:0] addr; logic [31:0] wdata; } beat_t;
    typedef struct packed { logic [31:0] rdata; logic hit; } resp_t;

    beat_t       exp_beats[$];
    resp_t       exp_resp[$];
    logic [31:0] mem_w [logic [31:0]];
    int          checks = 0;
    int          failures = 0;
    int          stall_cycles = 0;
    int          stall_cnt = 0;
    bit          have_held = 0;
    logic [31:0] held_addr, held_wdata;
    logic        held_write;
    beat_t       mon_e;
    int          cyc = 0;
    int          accept_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem_w.exists(a)) return mem_w[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory model: decides at the falling edge whether the next rising edge
    // completes the presented beat.
    always @(negedge clk) begin
        if (!reset_n) begin
            mem_ready = 1'b0;
            stall_cnt = 0;
            have_held = 0;
        end else if (mem_valid) begin
            checks++;
            if (cpu_req_ready !== 1'b0) begin
                failures++;
                $display("FAIL ready_during_burst cpu_req_ready=%b required 0 (addr %h)", cpu_req_ready, mem_addr);
            end
            if (have_held) begin
                checks++;
                if (mem_addr !== held_addr || mem_write !== held_write ||
                    (held_write && mem_wdata !== held_wdata)) begin
                    failures++;
                    $display("FAIL stall_stable addr=%h wdata=%h write=%b required addr=%h wdata=%h write=%b",
                             mem_addr, mem_wdata, mem_write, held_addr, held_wdata, held_write);
                end
            end
            if (stall_cnt < stall_cycles) begin
                mem_ready  = 1'b0;
                stall_cnt++;
                have_held  = 1;
                held_addr  = mem_addr;
                held_wdata = mem_wdata;
                held_write = mem_write;
            end else begin
                mem_ready = 1'b1;
                stall_cnt = 0;
                have_held = 0;
                checks++;
                if (exp_beats.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat write=%b addr=%h required no beat", mem_write, mem_addr);
                end else begin
                    mon_e = exp_beats.pop_front();
                    if (mem_write !== mon_e.write || mem_addr !== mon_e.addr ||
                        (mon_e.write && mem_wdata !== mon_e.wdata)) begin
                        failures++;
                        $display("FAIL beat write=%b addr=%h wdata=%h required write=%b addr=%h wdata=%h",
                                 mem_write, mem_addr, mem_wdata, mon_e.write, mon_e.addr, mon_e.wdata);
                    end
                end
                if (mem_write) mem_w[mem_addr] = mem_wdata;
                else           mem_rdata = mem_val(mem_addr);
            end
        end else begin
            mem_ready = 1'b0;
            stall_cnt = 0;
            have_held = 0;
        end
    end

    // Queue the four beats of a line; one word may carry modified data.
    task automatic push_line(input logic w, input logic [31:0] base,
                             input logic [31:0] mod_addr, input logic [31:0] mod_data);
        beat_t b;
        for (int i = 0; i < 4; i++) begin
            b.write = w;
            b.addr  = base + 32'(4 * i);
            b.wdata = (b.addr == mod_addr) ? mod_data : mem_val(b.addr);
            exp_beats.push_back(b);
        end
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, output bit ok);
        int n;
        ok = 1;
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_write = w;
        cpu_req_addr  = a;
        cpu_req_wdata = d;
        n = 0;
        while (cpu_req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            ok = 0;
            cpu_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        accept_cyc    = cyc;
        cpu_req_valid = 1'b0;
    endtask

    // Pushes the expected result, issues the request and returns what the
    // DUT answered; lat < 0 means no response arrived within the budget.
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_h,
                        output logic [31:0] rd, output logic h, output int lat);
        resp_t r;
        bit    ok;
        r.rdata = exp_rd;
        r.hit   = exp_h;
        exp_resp.push_back(r);
        rd  = '0;
        h   = 1'b0;
        lat = -1;
        issue(w, a, d, ok);
        if (!ok) return;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (cpu_resp_valid === 1'b1) begin
                rd  = cpu_resp_rdata;
                h   = cpu_resp_hit;
                lat = cyc - accept_cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_valid, mem_write, cpu_req_ready, cpu_resp_valid, cpu_resp_hit} !== 5'b00100 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || cpu_resp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs mv=%b mw=%b rdy=%b rv=%b rh=%b ma=%h md=%h rd=%h required 0,0,1,0,0,0,0,0",
                     mem_valid, mem_write, cpu_req_ready, cpu_resp_valid, cpu_resp_hit, mem_addr, mem_wdata, cpu_resp_rdata);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (perf_hits !== 32'd0 || perf_misses !== 32'd0 || cpu_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_counters hits=%0d misses=%0d ready=%b required 0 0 1", perf_hits, perf_misses, cpu_req_ready);
        end
    endtask

    task automatic test_cold_read();
        resp_t e; logic [31:0] rd; logic h; int lat;
        push_line(1'b0, 32'h040, 32'hFFFF_FFFF, 32'h0);
        xact(1'b0, 32'h040, 32'h0, 32'hA5A5_0040, 1'b0, rd, h, lat);
        e = exp_resp.pop_front();
        checks++;
        if (lat < 0 || rd !== e.rdata || h !== e.hit) begin
            failures++;
            $display("FAIL cold_read rdata=%h hit=%b lat=%0d required rdata=%h hit=%b", rd, h, lat, e.rdata, e.hit);
        end
        checks++;
        if (exp_beats.size() != 0) begin
            failures++;
            $display("FAIL cold_read_beats remaining=%0d required 0", exp_beats.size());
        end
        xact(1'b0, 32'h044, 32'h0, 32'hA5A5_0044, 1'b1, rd, h, lat);
        e = exp_resp.pop_front();
        checks++;
        if (rd !== e.rdata || h !== e.hit || lat !== 2) begin
            failures++;
            $display("FAIL read_hit rdata=%h hit=%b lat=%0d required rdata=%h hit=%b lat=2", rd, h, lat, e.rdata, e.hit);
        end
    endtask

    task automatic test_store_hit();
        resp_t e; logic [31:0] rd; logic h; int lat;
        xact(1'b1, 32'h044, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, rd, h, lat);
        e = exp_resp.pop_front();
        checks++;
        if (rd !== e.rdata || h !== e.hit || lat !== 2) begin
            failures++;
            $display("FAIL store_hit rdata=%h hit=%b lat=%0d required rdata=%h hit=%b lat=2", rd, h, lat, e.rdata, e.hit);
        end
        xact(1'b0, 32'h044, 32'h0, 32'hCAFE_F00D, 1'b1, rd, h, lat);
        e = exp_resp.pop_front();
        checks++;
        if (lat < 0 || rd !== e.rdata || h !== e.hit) begin
            failures++;
            $display("FAIL load_after_store rdata=%h hit=%b lat=%0d required rdata=%h hit=%b", rd, h, lat, e.rdata, e.hit);
        end
    endtask

    task automatic test_dirty_evict();
        resp_t e; logic [31:0] rd; logic h; int lat;
        push_line(1'b1, 32'h040, 32'h044, 32'hCAFE_F00D);
        push_line(1'b0, 32'h440, 32'hFFFF_FFFF, 32'h0);
        xact(1'b0, 32'h440, 32'h0, 32'hA5A5_0440, 1'b0, rd, h, lat);
        e = exp_resp.pop_front();
        checks++;
        if (lat < 0 || rd !== e.rdata || h !== e.hit) begin
            failures++;
            $display("FAIL dirty_evict rdata=%h hit=%b lat=%0d required rdata=%h hit=%b", rd, h, lat, e.rdata, e.hit);
        end
        checks++;
        if (exp_beats.size() != 0 || perf_hits !== 32'd3 || perf_misses !== 32'd2) begin
            failures++;
            $display("FAIL evict_counts beats_left=%0d hits=%0d misses=%0d required 0 3 2", exp_beats.size(), perf_hits, perf_misses);
        end
    endtask

    task automatic test_store_miss();
        resp_t e; logic [31:0] rd; logic h; int lat;
        push_line(1'b0, 32'h800, 32'hFFFF_FFFF, 32'h0);
        xact(1'b1, 32'h800, 32'h1234_5678, 32'h1234_5678, 1'b0, rd, h, lat);
        e = exp_resp.pop_front();
        checks++;
        if (lat < 0 || rd !== e.rdata || h !== e.hit || exp_beats.size() != 0) begin
            failures++;
            $display("FAIL store_miss rdata=%h hit=%b lat=%0d beats_left=%0d required rdata=%h hit=%b beats_left=0",
                     rd, h, lat, exp_beats.size(), e.rdata, e.hit);
        end
        xact(1'b0, 32'h800, 32'h0, 32'h1234_5678, 1'b1, rd, h, lat);
        e = exp_resp.pop_front();
        checks++;
        if (lat < 0 || rd !== e.rdata || h !== e.hit) begin
            failures++;
            $display("FAIL store_miss_reload rdata=%h hit=%b lat=%0d required rdata=%h hit=%b", rd, h, lat, e.rdata, e.hit);
        end
    endtask

    task automatic test_stall();
        resp_t e; logic [31:0] rd; logic h; int lat;
        stall_cycles = 5;
        push_line(1'b1, 32'h800, 32'h800, 32'h1234_5678);
        push_line(1'b0, 32'hC00, 32'hFFFF_FFFF, 32'h0);
        xact(1'b0, 32'hC00, 32'h0, 32'hA5A5_0C00, 1'b0, rd, h, lat);
        e = exp_resp.pop_front();
        checks++;
        if (lat < 0 || rd !== e.rdata || h !== e.hit || exp_beats.size() != 0) begin
            failures++;
            $display("FAIL stalled_miss rdata=%h hit=%b lat=%0d beats_left=%0d required rdata=%h hit=%b beats_left=0",
                     rd, h, lat, exp_beats.size(), e.rdata, e.hit);
        end
        stall_cycles = 0;
        xact(1'b0, 32'hC08, 32'h0, 32'hA5A5_0C08, 1'b1, rd, h, lat);
        e = exp_resp.pop_front();
        checks++;
        if (rd !== e.rdata || h !== e.hit || lat !== 2) begin
            failures++;
            $display("FAIL stalled_line_hit rdata=%h hit=%b lat=%0d required rdata=%h hit=%b lat=2", rd, h, lat, e.rdata, e.hit);
        end
        checks++;
        if (perf_hits !== 32'd5 || perf_misses !== 32'd4) begin
            failures++;
            $display("FAIL perf_counts hits=%0d misses=%0d required 5 4", perf_hits, perf_misses);
        end
    endtask

    task automatic test_reset_mid_burst();
        resp_t e; logic [31:0] rd; logic h; int lat; bit ok; bit seen;
        push_line(1'b0, 32'h1040, 32'hFFFF_FFFF, 32'h0);
        issue(1'b0, 32'h1040, 32'h0, ok);
        seen = 0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            #2;
            if (mem_valid === 1'b1 && mem_addr === 32'h1048) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL reach_beat2 seen=0 required 1");
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_valid, mem_write, cpu_req_ready, cpu_resp_valid, cpu_resp_hit} !== 5'b00100 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || cpu_resp_rdata !== 32'h0 ||
            perf_hits !== 32'd0 || perf_misses !== 32'd0) begin
            failures++;
            $display("FAIL mid_burst_reset mv=%b rdy=%b rv=%b ma=%h rd=%h hits=%0d misses=%0d required 0 1 0 0 0 0 0",
                     mem_valid, cpu_req_ready, cpu_resp_valid, mem_addr, cpu_resp_rdata, perf_hits, perf_misses);
        end
        exp_beats.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        push_line(1'b0, 32'h1040, 32'hFFFF_FFFF, 32'h0);
        xact(1'b0, 32'h1040, 32'h0, 32'hA5A5_1040, 1'b0, rd, h, lat);
        e = exp_resp.pop_front();
        checks++;
        if (lat < 0 || rd !== e.rdata || h !== e.hit || exp_beats.size() != 0) begin
            failures++;
            $display("FAIL reload_after_reset rdata=%h hit=%b lat=%0d beats_left=%0d required rdata=%h hit=%b beats_left=0",
                     rd, h, lat, exp_beats.size(), e.rdata, e.hit);
        end
        checks++;
        if (perf_hits !== 32'd0 || perf_misses !== 32'd1) begin
            failures++;
            $display("FAIL reload_counts hits=%0d misses=%0d required 0 1", perf_hits, perf_misses);
        end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_store_hit();
        test_dirty_evict();
        test_store_miss();
        test_stall();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
